// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronised SPI inputs, configurable mode/width/bit order,
// first-word-fall-through word FIFO with sticky overflow and partial-word flags.
module spi_slave_rx #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            Clk,
  input  logic                            RstN,
  input  logic                            Sclk,
  input  logic                            Mosi,
  input  logic                            CSel,
  output logic [DATA_WIDTH-1:0]           DataOut,
  output logic                            DataValid,
  input  logic                            DataReady,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Level,
  output logic                            Busy,
  output logic                            FrameStart,
  output logic                            FrameEnd,
  output logic                            Overflow,
  output logic                            FrameError,
  input  logic                            StatusClr
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic SAMPLE_LVL = (CPOL == CPHA);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csel_sync;
  logic                   sclk_prev, csel_prev;
  logic                   sclk_s, mosi_s, csel_s;
  logic                   sample_edge, csel_fall, csel_rise;

  // CSel chain resets asserted so a frame already running at reset release is skipped
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      csel_sync <= '0;
      sclk_prev <= CPOL;
      csel_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], Sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], Mosi};
      csel_sync <= {csel_sync[SYNC_STAGES-2:0], CSel};
      sclk_prev <= sclk_s;
      csel_prev <= csel_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign csel_s      = csel_sync[SYNC_STAGES-1];
  assign sample_edge = (sclk_s != sclk_prev) && (sclk_s == SAMPLE_LVL);
  assign csel_fall   = csel_prev & ~csel_s;
  assign csel_rise   = ~csel_prev & csel_s;

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  push, fs_d, fe_d, ferr_set;

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) shifted = {shreg_q[DATA_WIDTH-2:0], mosi_s};
    else           shifted = {mosi_s, shreg_q[DATA_WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (csel_fall) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
          fs_d    = 1'b1;
        end
      end
      SHIFT: begin
        // deselect takes priority over a coincident sample edge
        if (csel_rise) begin
          state_d  = IDLE;
          fe_d     = 1'b1;
          ferr_set = (cnt_q != '0);
        end else if (sample_edge) begin
          shreg_d = shifted;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            push  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         count;
  logic                  full, pop, do_push, ovf_set;

  assign full      = (count == LW'(FIFO_DEPTH));
  assign DataValid = (count != '0);
  assign pop       = DataValid && DataReady;
  assign do_push   = push && (!full || pop);
  assign ovf_set   = push && full && !pop;
  assign DataOut   = mem[rd_ptr];
  assign Level     = count;
  assign Busy      = (state_q == SHIFT);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      FrameStart <= 1'b0;
      FrameEnd   <= 1'b0;
      Overflow   <= 1'b0;
      FrameError <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      FrameStart <= fs_d;
      FrameEnd   <= fe_d;
      Overflow   <= ovf_set | (Overflow & ~StatusClr);
      FrameError <= ferr_set | (FrameError & ~StatusClr);
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shifted;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
